// File: rtl/ext_aes_sequencer_if.sv
// Command, data-memory and AES-core signals of the AES extension sequencer.
// The master modport is the sequencer side; slave is its environment.
interface ext_aes_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 12
);
  logic              cmd_valid;
  logic [2:0]        cmd_sel;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [CNT_W-1:0]  cmd_cnt;
  logic              stall;
  logic              done;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_byteena;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              eng_start;
  logic              eng_decrypt;
  logic [127:0]      eng_in;
  logic              eng_done;
  logic [127:0]      eng_out;

  modport master (
    input  cmd_valid, cmd_sel, cmd_src, cmd_dst, cmd_cnt,
    input  mem_ack, mem_rdata, eng_done, eng_out,
    output stall, done, err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_byteena,
    output eng_start, eng_decrypt, eng_in
  );

  modport slave (
    output cmd_valid, cmd_sel, cmd_src, cmd_dst, cmd_cnt,
    output mem_ack, mem_rdata, eng_done, eng_out,
    input  stall, done, err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_byteena,
    input  eng_start, eng_decrypt, eng_in
  );
endinterface

// File: rtl/ext_aes_sequencer.sv
// Streams cmd_cnt 128-bit words from src through the AES core to dst, stalling
// the pipeline until the whole transfer retires. All outputs are registered.
module ext_aes_sequencer #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 12
) (
  input logic clk,
  input logic rst_n,
  ext_aes_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD, ENG_GO, ENG_WAIT, WR, FIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        k_q, k_d;
  logic              dec_q, dec_d, bad_q, bad_d;
  logic [127:0]      buf_q, buf_d;

  logic              stall_q, stall_d, done_q, done_d, err_q, err_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, word_ofs;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_byteena_q, mem_byteena_d;
  logic              eng_start_q, eng_start_d, eng_decrypt_q, eng_decrypt_d;

  logic unused_lsbs;
  assign unused_lsbs = ^{bus.cmd_src[1:0], bus.cmd_dst[1:0]};

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    dec_d   = dec_q;
    bad_d   = bad_q;
    buf_d   = buf_q;

    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        src_d   = {bus.cmd_src[ADDR_W-1:2], 2'b00};
        dst_d   = {bus.cmd_dst[ADDR_W-1:2], 2'b00};
        cnt_d   = bus.cmd_cnt;
        dec_d   = (bus.cmd_sel == 3'd2);
        bad_d   = !((bus.cmd_sel == 3'd1) || (bus.cmd_sel == 3'd2));
        k_d     = 2'd0;
        state_d = (bad_d || (bus.cmd_cnt == '0)) ? FIN : RD;
      end
      RD: if (bus.mem_ack) begin
        buf_d[{k_q, 5'b0} +: 32] = bus.mem_rdata;
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = ENG_GO;
      end
      ENG_GO: state_d = ENG_WAIT;
      ENG_WAIT: if (bus.eng_done) begin
        buf_d   = bus.eng_out;
        state_d = WR;
      end
      WR: if (bus.mem_ack) begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          src_d   = src_q + ADDR_W'(16);
          dst_d   = dst_q + ADDR_W'(16);
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? FIN : RD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs decode from the next state so they line up with it once registered.
    word_ofs      = {{(ADDR_W-4){1'b0}}, k_d, 2'b00};
    stall_d       = (state_d != IDLE);
    done_d        = (state_d == FIN);
    err_d         = done_d && bad_d;
    mem_req_d     = (state_d == RD) || (state_d == WR);
    mem_we_d      = (state_d == WR);
    mem_byteena_d = mem_req_d ? 4'hF : 4'h0;
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    if (state_d == RD) mem_addr_d = src_d + word_ofs;
    if (state_d == WR) begin
      mem_addr_d  = dst_d + word_ofs;
      mem_wdata_d = buf_d[{k_d, 5'b0} +: 32];
    end
    eng_start_d   = (state_d == ENG_GO);
    eng_decrypt_d = (state_d != IDLE) && dec_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      cnt_q         <= '0;
      k_q           <= '0;
      dec_q         <= 1'b0;
      bad_q         <= 1'b0;
      buf_q         <= '0;
      stall_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_byteena_q <= '0;
      eng_start_q   <= 1'b0;
      eng_decrypt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      cnt_q         <= cnt_d;
      k_q           <= k_d;
      dec_q         <= dec_d;
      bad_q         <= bad_d;
      buf_q         <= buf_d;
      stall_q       <= stall_d;
      done_q        <= done_d;
      err_q         <= err_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_byteena_q <= mem_byteena_d;
      eng_start_q   <= eng_start_d;
      eng_decrypt_q <= eng_decrypt_d;
    end
  end

  assign bus.stall       = stall_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_byteena = mem_byteena_q;
  assign bus.eng_start   = eng_start_q;
  assign bus.eng_decrypt = eng_decrypt_q;
  assign bus.eng_in      = buf_q;
endmodule
